// File: rtl/mod_div2k_pkg.sv
// rtl/mod_div2k_pkg.sv - shared defaults, state enum and HALF helper for modular 2^-k scaling
package mod_div2k_pkg;

    localparam int DEF_Q    = 12289;
    localparam int DEF_W    = 14;
    localparam int DEF_KMAX = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Multiplicative inverse of 2 modulo an odd q.
    function automatic int half_of(input int q);
        return (q + 1) / 2;
    endfunction

endpackage

// File: rtl/mod_half_step.sv
// rtl/mod_half_step.sv - combinational modular halving a -> a * 2^-1 mod Q
module mod_half_step
    import mod_div2k_pkg::*;
#(
    parameter int Q = DEF_Q,
    parameter int W = DEF_W
) (
    input  logic [W-1:0] a_i,
    output logic [W-1:0] a_o
);

    localparam logic [W-1:0] HALF = W'(half_of(Q));

    logic [W-1:0] shifted;

    // (a >> 1) + HALF stays below 2^W for any a < 2^W, so a W-bit add loses nothing.
    always_comb begin
        shifted = {1'b0, a_i[W-1:1]};
        a_o     = a_i[0] ? (shifted + HALF) : shifted;
    end

endmodule

// File: rtl/mod_div2k_iter.sv
// rtl/mod_div2k_iter.sv - iterative y = x * 2^-k mod Q, one halving per cycle; optional MOD_DIV2K_PRERED_EN
module mod_div2k_iter
    import mod_div2k_pkg::*;
#(
    parameter int Q    = DEF_Q,
    parameter int W    = DEF_W,
    parameter int KMAX = DEF_KMAX,
    parameter int KW   = $clog2(KMAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_x,
    input  logic [KW-1:0] in_k,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_y,
    output logic          busy
);

    localparam logic [KW-1:0] KMAX_K = KW'(KMAX);

    state_e        state_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  out_y_q;
    logic [KW-1:0] cnt_q;
    logic          out_valid_q;

    logic [W-1:0]  acc_d;
    logic [W-1:0]  step_y;
    logic [KW-1:0] k_clamp;

    mod_half_step #(
        .Q (Q),
        .W (W)
    ) u_half_step (
        .a_i (acc_q),
        .a_o (step_y)
    );

    always_comb begin
        k_clamp = (in_k > KMAX_K) ? KMAX_K : in_k;
    end

`ifdef MOD_DIV2K_PRERED_EN
    localparam logic [W-1:0] Q_W = W'(Q);

    // One conditional subtraction: operands in 0..2Q-1 become canonical.
    always_comb begin
        acc_d = (in_x >= Q_W) ? (in_x - Q_W) : in_x;
    end
`else
    always_comb begin
        acc_d = in_x;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_q <= acc_d;
                        cnt_q <= k_clamp;
                        if (k_clamp == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            out_y_q     <= acc_d;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_q <= step_y;
                    cnt_q <= cnt_q - 1'b1;
                    // Last step lands directly in the output register.
                    if (cnt_q == KW'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_y_q     <= step_y;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;

endmodule

// File: tb/tb_mod_div2k_iter.sv
// tb/tb_mod_div2k_iter.sv - directed and property checks for mod_div2k_iter
module tb_mod_div2k_iter;

    localparam int Q    = 12289;
    localparam int W    = 14;
    localparam int KMAX = 10;
    localparam int KW   = $clog2(KMAX + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_x;
    logic [KW-1:0] in_k;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_y;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    mod_div2k_iter #(
        .Q    (Q),
        .W    (W),
        .KMAX (KMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_k      (in_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Accept one operand, wait for the result, hold off out_ready for hold cycles, then consume.
    task automatic do_op(input logic [W-1:0] x, input logic [KW-1:0] k, input int hold,
                         output logic [W-1:0] y, output int lat);
        @(negedge clk);
        check("accept_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_x     = x;
        in_k     = k;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("result_timeout", {31'b0, out_valid}, 32'd1);
        y = out_y;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] y;
        int           lat;
        logic [W-1:0] rx;
        logic [KW-1:0] rk;
        longint       p;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_k      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_y",     {18'b0, out_y},     32'd0);
        check("rst_busy",      {31'b0, busy},      32'd0);

        do_op(14'd1, 4'd1, 0, y, lat);
        check("x1_k1_y", {18'b0, y}, 32'd6145);
        check("x1_k1_lat", lat, 32'd2);
        do_op(14'd2, 4'd1, 0, y, lat);
        check("x2_k1_y", {18'b0, y}, 32'd1);
        do_op(14'd12288, 4'd1, 0, y, lat);
        check("x12288_k1_y", {18'b0, y}, 32'd6144);
        do_op(14'd1, 4'd2, 0, y, lat);
        check("x1_k2_y", {18'b0, y}, 32'd9217);
        check("x1_k2_lat", lat, 32'd3);
        do_op(14'd1, 4'd10, 0, y, lat);
        check("x1_k10_y", {18'b0, y}, 32'd12277);
        check("x1_k10_lat", lat, 32'd11);
        do_op(14'd5, 4'd0, 0, y, lat);
        check("x5_k0_y", {18'b0, y}, 32'd5);
        check("x5_k0_lat", lat, 32'd1);
        do_op(14'd1, 4'd15, 0, y, lat);
        check("k15_clamp_y", {18'b0, y}, 32'd12277);
        check("k15_clamp_lat", lat, 32'd11);
        do_op(14'd12290, 4'd1, 0, y, lat);
        check("x12290_k1_y", {18'b0, y}, 32'd6145);
        do_op(14'd12291, 4'd0, 0, y, lat);
`ifdef MOD_DIV2K_PRERED_EN
        check("x12291_k0_y", {18'b0, y}, 32'd2);
`else
        check("x12291_k0_y", {18'b0, y}, 32'd12291);
`endif

        // Backpressure: x=3,k=1 -> 1 + 6145.
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = 14'd3;
        in_k     = 4'd1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",    {31'b0, out_valid}, 32'd1);
            check("bp_y",        {18'b0, out_y},     32'd6146);
            check("bp_in_ready", {31'b0, in_ready},  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("bp_rel_in_ready_before", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_rel_in_ready_after", {31'b0, in_ready},  32'd1);
        check("bp_rel_valid_after",    {31'b0, out_valid}, 32'd0);

        // Abort mid-RUN with k=10.
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = 14'd1;
        in_k     = 4'd10;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",      {31'b0, busy},      32'd0);
        check("abort_in_ready",  {31'b0, in_ready},  32'd1);
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_out_y",     {18'b0, out_y},     32'd0);
        do_op(14'd2, 4'd1, 0, y, lat);
        check("post_abort_y", {18'b0, y}, 32'd1);

        // Property: y * 2^k == x (mod Q), y < Q, latency k+1, under random backpressure.
        for (int n = 0; n < 1000; n++) begin
            rx = W'($urandom_range(0, Q - 1));
            rk = KW'($urandom_range(0, KMAX));
            do_op(rx, rk, $urandom_range(0, 3), y, lat);
            p = longint'(y);
            for (int j = 0; j < int'(rk); j++) p = (p * 2) % Q;
            check("rnd_inverse", p[31:0], {18'b0, rx});
            check("rnd_range", {31'b0, (y < W'(Q))}, 32'd1);
            check("rnd_lat", lat, int'(rk) + 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
